shiftreg: RTL and testbench
===========================

SHIFTREG -- requirements
Module: shiftreg

Interface
REQ-001 SHALL have parameter M_WIDTH, default 3, width of count and random_out (>=1).
REQ-002 SHALL have parameter INPUT_WIDTH, default 10, width of in (>=2); H = floor(INPUT_WIDTH/2).
REQ-003 SHALL have port: clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: in  input  INPUT_WIDTH  raw entropy word, sampled at operation start.
REQ-006 SHALL have port: count  input  M_WIDTH  unsigned rotate amount, sampled at operation start.
REQ-007 SHALL have port: start_shift  input  1  level request; operation may start while high.
REQ-008 SHALL have port: done_shift  output  1  rotate phase of current operation complete.
REQ-009 SHALL have port: random_out  output  M_WIDTH  history register of extracted bits.
REQ-010 SHALL have port: done_upcount  output  1  scan phase complete, random_out updated.

Function
REQ-011 SHALL implement states IDLE, SHIFT, UPCOUNT, DONE; every transition occurs on a clock edge.
REQ-012 IDLE: SHALL accept when start_shift=1 AND (no operation completed since reset OR count != last accepted count): load shreg<=in, rem<=count, last<=count, go SHIFT.
REQ-013 IDLE with start_shift=1 and count equal to last accepted count SHALL stay IDLE (no re-run, random_out unchanged).
REQ-014 SHIFT: per edge, if rem!=0 rotate shreg right one bit ({shreg[0],shreg[W-1:1]}) and decrement rem; if rem==0 set done_shift<=1, clear scan index and parity, go UPCOUNT.
REQ-015 UPCOUNT: per edge, parity ^= shreg[idx], idx increments 0..H-1; on the edge handling idx=H-1 set random_out<={random_out[M_WIDTH-2:0],p} (p = final parity; for M_WIDTH=1 random_out<=p), set done_upcount<=1, go DONE.
REQ-016 DONE: both flags high for exactly one cycle; next edge clears both flags, go IDLE.
REQ-017 Latency: with acceptance at edge E0, done_shift rises at E0+count+1, done_upcount at E0+count+1+H; both fall at E0+count+2+H.
REQ-018 done_shift SHALL stay high from its rise until DONE exits; flags never high in IDLE.
REQ-019 count=0 SHALL perform no rotation (SHIFT lasts one edge).
REQ-020 start_shift deassertion after acceptance SHALL NOT abort the operation; in/count changes mid-operation SHALL be ignored.
REQ-021 rem, idx SHALL not wrap; all arithmetic unsigned, sized to hold M_WIDTH-bit count and H.

Reset
REQ-022 rst=0 at a clock edge SHALL force IDLE, done_shift=0, done_upcount=0, random_out=0, shreg=0, clear the "last count valid" flag; applies mid-operation (operation discarded).
REQ-023 Reset SHALL take precedence over all other activity in that cycle.

Configuration
REQ-024 Macro SHIFTREG_FAST_SHIFT_EN: when defined, SHIFT SHALL rotate right by count in a single edge (barrel rotate), set done_shift and go UPCOUNT; done_shift at E0+1, done_upcount at E0+1+H.
REQ-025 Without SHIFTREG_FAST_SHIFT_EN, SHALL use one-bit-per-cycle rotation per REQ-014; extracted bits identical in both builds.

Verification (M_WIDTH=3, INPUT_WIDTH=10, H=5)
REQ-026 Reset, in=10'b0000011111, count=0, start_shift=1 at E0 -> done_shift at E1, done_upcount at E6, random_out=3'b001, flags low at E7.
REQ-027 After reset, in=10'b0000011111, count=5 -> rotated 10'b1111100000, p=0, random_out=3'b000, done_upcount at E0+11.
REQ-028 After reset, start_shift held high, in=10'b0000011111, count stepped 7 -> 6 -> 5 after each done pulse -> p=0,1,0, random_out 000 -> 001 -> 010.
REQ-029 After completion with count=6, keep start_shift=1 and count=6 for 20 cycles -> no new operation, flags stay 0, random_out unchanged.
REQ-030 rst=0 during UPCOUNT of an operation -> next edge flags 0, random_out 0, state IDLE; identical count then re-accepted.
REQ-031 With SHIFTREG_FAST_SHIFT_EN, in=10'b0000011111, count=7 -> done_shift at E1, done_upcount at E6, p=0 (rotated 10'b0011111000).

Source files
------------

// File: rtl/shiftreg.sv
// Entropy extractor: rotates a sampled word by `count`, folds the parity of its low half
// into a history register. Optional SHIFTREG_FAST_SHIFT_EN does the rotate in one edge.
module shiftreg #(
    parameter int M_WIDTH     = 3,
    parameter int INPUT_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INPUT_WIDTH-1:0] in,
    input  logic [M_WIDTH-1:0]     count,
    input  logic                   start_shift,
    output logic                   done_shift,
    output logic [M_WIDTH-1:0]     random_out,
    output logic                   done_upcount
);

    localparam int H     = INPUT_WIDTH / 2;
    localparam int IDX_W = (H > 1) ? $clog2(H) : 1;

    // Handshake: start_shift is a level request sampled only in IDLE; once accepted the
    // operation runs to completion regardless of start_shift, in or count. done_shift
    // marks the end of the rotate phase and stays high until DONE exits; done_upcount
    // pulses for the single DONE cycle in which random_out carries the new bit.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        UPCOUNT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [INPUT_WIDTH-1:0] shreg;
    logic [INPUT_WIDTH-1:0] shreg_next;
    logic [M_WIDTH-1:0]     rem;
    logic [M_WIDTH-1:0]     rem_next;
    logic [M_WIDTH-1:0]     last;
    logic [M_WIDTH-1:0]     last_next;
    logic                   last_valid;
    logic                   last_valid_next;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       idx_next;
    logic                   parity;
    logic                   parity_next;
    logic                   done_shift_next;
    logic                   done_upcount_next;
    logic [M_WIDTH-1:0]     random_next;
    logic                   bit_p;
    logic [M_WIDTH-1:0]     random_shifted;

`ifdef SHIFTREG_FAST_SHIFT_EN
    // Logarithmic rotator: stage b rotates right by 2**b (mod width) when n[b] is set.
    function automatic logic [INPUT_WIDTH-1:0] rotate_right(
        input logic [INPUT_WIDTH-1:0] x,
        input logic [M_WIDTH-1:0]     n
    );
        logic [INPUT_WIDTH-1:0]   r;
        logic [2*INPUT_WIDTH-1:0] d;
        r = x;
        for (int b = 0; b < M_WIDTH; b++) begin
            if (n[b]) begin
                d = {r, r};
                r = d[((2 ** b) % INPUT_WIDTH) +: INPUT_WIDTH];
            end
        end
        return r;
    endfunction
`endif

    assign bit_p = parity ^ shreg[idx];

    generate
        if (M_WIDTH == 1) begin : g_hist_single
            assign random_shifted = bit_p;
        end else begin : g_hist_multi
            assign random_shifted = {random_out[M_WIDTH-2:0], bit_p};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            shreg        <= '0;
            rem          <= '0;
            last         <= '0;
            last_valid   <= 1'b0;
            idx          <= '0;
            parity       <= 1'b0;
            done_shift   <= 1'b0;
            done_upcount <= 1'b0;
            random_out   <= '0;
        end else begin
            state        <= state_next;
            shreg        <= shreg_next;
            rem          <= rem_next;
            last         <= last_next;
            last_valid   <= last_valid_next;
            idx          <= idx_next;
            parity       <= parity_next;
            done_shift   <= done_shift_next;
            done_upcount <= done_upcount_next;
            random_out   <= random_next;
        end
    end

    always_comb begin
        state_next        = state;
        shreg_next        = shreg;
        rem_next          = rem;
        last_next         = last;
        last_valid_next   = last_valid;
        idx_next          = idx;
        parity_next       = parity;
        done_shift_next   = done_shift;
        done_upcount_next = done_upcount;
        random_next       = random_out;

        case (state)
            IDLE: begin
                // A repeated request with the count of the last completed run is ignored.
                if (start_shift && (!last_valid || (count != last))) begin
                    shreg_next = in;
                    rem_next   = count;
                    last_next  = count;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
`ifdef SHIFTREG_FAST_SHIFT_EN
                shreg_next      = rotate_right(shreg, rem);
                rem_next        = '0;
                done_shift_next = 1'b1;
                idx_next        = '0;
                parity_next     = 1'b0;
                state_next      = UPCOUNT;
`else
                if (rem != '0) begin
                    shreg_next = {shreg[0], shreg[INPUT_WIDTH-1:1]};
                    rem_next   = rem - M_WIDTH'(1);
                end else begin
                    done_shift_next = 1'b1;
                    idx_next        = '0;
                    parity_next     = 1'b0;
                    state_next      = UPCOUNT;
                end
`endif
            end
            UPCOUNT: begin
                parity_next = bit_p;
                if (idx == IDX_W'(H - 1)) begin
                    random_next       = random_shifted;
                    done_upcount_next = 1'b1;
                    last_valid_next   = 1'b1;
                    state_next        = DONE;
                end else begin
                    idx_next = idx + IDX_W'(1);
                end
            end
            DONE: begin
                done_shift_next   = 1'b0;
                done_upcount_next = 1'b0;
                state_next        = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shiftreg.sv
// Directed bench for shiftreg (M_WIDTH=3, INPUT_WIDTH=10): vector table of operations
// plus hand sequences for repeated-count hold and mid-operation reset.
module tb_shiftreg;

    localparam int W = 10;
    localparam int M = 3;
    localparam int H = W / 2;
`ifdef SHIFTREG_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] in;
    logic [M-1:0] count;
    logic         start_shift;
    logic         done_shift;
    logic [M-1:0] random_out;
    logic         done_upcount;

    int n_checks = 0;
    int n_pass   = 0;

    shiftreg #(.M_WIDTH(M), .INPUT_WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in           (in),
        .count        (count),
        .start_shift  (start_shift),
        .done_shift   (done_shift),
        .random_out   (random_out),
        .done_upcount (done_upcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         do_reset;
        logic [W-1:0] in_v;
        logic [M-1:0] cnt;
        logic         perturb;
        logic [M-1:0] exp_rand;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start_shift = 1'b0;
        step();
        step();
        check("reset_flags", {30'd0, done_shift, done_upcount}, 32'd0);
        check("reset_random", {29'd0, random_out}, 32'd0);
        rst = 1'b1;
    endtask

    // One accepted operation; flags are checked on every edge up to the falling edge.
    task automatic run_op(input string name, input logic [W-1:0] iv, input logic [M-1:0] cv,
                          input logic pert, input logic [M-1:0] exp_r);
        int ls;
        int lu;
        ls = FAST ? 1 : int'(cv) + 1;
        lu = ls + H;
        in = iv;
        count = cv;
        start_shift = 1'b1;
        step();
        if (pert) begin
            start_shift = 1'b0;
            in = ~iv;
            count = cv + 3'd3;
        end
        for (int k = 1; k <= lu + 1; k++) begin
            step();
            check($sformatf("%s_ds_e%0d", name, k), {31'd0, done_shift},
                  {31'd0, (k >= ls) && (k <= lu)});
            check($sformatf("%s_du_e%0d", name, k), {31'd0, done_upcount},
                  {31'd0, k == lu});
        end
        check($sformatf("%s_random", name), {29'd0, random_out}, {29'd0, exp_r});
    endtask

    initial begin
        int ls;
        rst = 1'b0;
        in = '0;
        count = '0;
        start_shift = 1'b0;

        vecs[0] = '{1'b1, 10'b0000011111, 3'd0, 1'b0, 3'b001};
        vecs[1] = '{1'b1, 10'b0000011111, 3'd5, 1'b0, 3'b000};
        vecs[2] = '{1'b1, 10'b0000011111, 3'd7, 1'b0, 3'b000};
        vecs[3] = '{1'b0, 10'b0000011111, 3'd6, 1'b0, 3'b001};
        vecs[4] = '{1'b0, 10'b0000011111, 3'd5, 1'b0, 3'b010};
        vecs[5] = '{1'b0, 10'b1010110011, 3'd3, 1'b1, 3'b101};
        vecs[6] = '{1'b0, 10'b1111111111, 3'd1, 1'b0, 3'b011};
        vecs[7] = '{1'b0, 10'b0000000000, 3'd2, 1'b1, 3'b110};
        vecs[8] = '{1'b0, 10'b0000100000, 3'd1, 1'b0, 3'b101};

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].do_reset) do_reset();
            run_op($sformatf("vec%0d", i), vecs[i].in_v, vecs[i].cnt,
                   vecs[i].perturb, vecs[i].exp_rand);
        end

        // Same count held with start high after a completed run: no re-run.
        do_reset();
        run_op("hold_op", 10'b0000011111, 3'd6, 1'b0, 3'b001);
        for (int k = 0; k < 20; k++) begin
            step();
            check($sformatf("hold_flags_%0d", k), {30'd0, done_shift, done_upcount}, 32'd0);
        end
        check("hold_random", {29'd0, random_out}, 32'd1);

        // Reset during UPCOUNT discards the run; the same count is then accepted again.
        ls = FAST ? 1 : 5;
        in = 10'b0000011111;
        count = 3'd4;
        start_shift = 1'b1;
        step();
        for (int k = 1; k <= ls + 1; k++) step();
        check("midrst_ds_before", {31'd0, done_shift}, 32'd1);
        rst = 1'b0;
        step();
        check("midrst_flags", {30'd0, done_shift, done_upcount}, 32'd0);
        check("midrst_random", {29'd0, random_out}, 32'd0);
        rst = 1'b1;
        run_op("rerun", 10'b0000011111, 3'd4, 1'b0, 3'b001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
